// File: rtl/shift_row_stream.sv
// shift_row_stream: Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8
// columns. The row permutation is combinational on the input beat. Results
// are queued in a 2-entry FIFO with valid/ready handshakes on both sides.
module shift_row_stream #(
  parameter int unsigned NB     = 4,
  parameter bit          INV_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_state
);

  localparam int unsigned W = 32 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_row_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  // Row offsets: {0,1,2,3} for NB=4/6, {0,1,3,4} for NB=8.
  function automatic int unsigned row_shift(input int unsigned r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic         inv;
  logic [W-1:0] shifted;

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  // Per-beat row permutation; row 0 always keeps its position.
  always_comb begin
    int unsigned src;
    inv     = INV_EN ? in_inv : 1'b0;
    shifted = '0;
    src     = 0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < NB; c++) begin
        src = inv ? (c + NB - row_shift(r)) % NB : (c + row_shift(r)) % NB;
        shifted[W-1-32*c-8*r -: 8] = in_state[W-1-32*src-8*r -: 8];
      end
    end
  end

  // FIFO next-state. in_ready is registered from the next occupancy so
  // out_ready never reaches in_ready combinationally.
  always_comb begin
    push     = in_valid & in_ready_q;
    pop      = (count_q != 2'd0) & out_ready;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) mem_d[wr_ptr_q] = shifted;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
    in_ready_d = (count_d != 2'd2);
  end

  // State registers; reset clears storage so out_state reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_state = mem_q[rd_ptr_q];

endmodule
